// File: rtl/pos_eval_sweep.sv
// Product-of-sums truth-table sweeper: evaluates the latched POS expression
// for every input combination in order and accumulates the truth table and
// the count of true minterms.
module pos_eval_sweep #(
  parameter int unsigned N = 3,
  parameter int unsigned M = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             hold,
  input  logic [M*N-1:0]   lit_en,
  input  logic [M*N-1:0]   lit_neg,
  output logic             busy,
  output logic             valid,
  output logic [N-1:0]     vec,
  output logic             f,
  output logic             done,
  output logic [2**N-1:0]  tt,
  output logic [N:0]       ones
);

  localparam int unsigned VW = N;
  localparam int unsigned OW = N + 1;
  localparam int unsigned NV = 2 ** N;
  localparam int unsigned LW = M * N;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [LW-1:0]   r_en;
  logic [LW-1:0]   r_neg;
  logic [VW-1:0]   r_vec;
  logic [NV-1:0]   r_tt;
  logic [OW-1:0]   r_ones;
  logic [M-1:0]    w_clause;
  logic            w_f;
  logic            w_last;
  logic            w_adv;
  logic            w_accept;

  // Clause evaluation: an empty clause stays 0, so f collapses to 0.
  always_comb begin
    w_clause = '0;
    for (int j = 0; j < int'(M); j++) begin
      for (int i = 0; i < int'(N); i++) begin
        w_clause[j] = w_clause[j] | (r_en[j*N+i] & (r_vec[i] ^ r_neg[j*N+i]));
      end
    end
    w_f = &w_clause;
  end

  assign w_last   = (r_vec == {VW{1'b1}});
  assign w_accept = (r_state == ST_IDLE) && start;

  // Next-state logic; w_adv marks an evaluated (non-held) sweep cycle.
  always_comb begin
    w_next = r_state;
    w_adv  = 1'b0;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_SWEEP;
      ST_SWEEP: begin
        if (!hold) begin
          w_adv = 1'b1;
          if (w_last) w_next = ST_DONE;
        end
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Mask latch, sweep counter and result accumulation; vec parks at the top value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_en   <= '0;
      r_neg  <= '0;
      r_vec  <= '0;
      r_tt   <= '0;
      r_ones <= '0;
    end else if (w_accept) begin
      r_en   <= lit_en;
      r_neg  <= lit_neg;
      r_vec  <= '0;
      r_tt   <= '0;
      r_ones <= '0;
    end else if (w_adv) begin
      r_tt[r_vec] <= w_f;
      r_ones      <= r_ones + OW'(w_f);
      if (!w_last) r_vec <= r_vec + VW'(1);
    end
  end

  assign busy  = (r_state == ST_SWEEP);
  assign valid = (r_state == ST_SWEEP) && !hold;
  assign done  = (r_state == ST_DONE);
  assign vec   = r_vec;
  assign f     = w_f;
  assign tt    = r_tt;
  assign ones  = r_ones;

endmodule

// File: tb/tb_pos_eval_sweep.sv
// Bench for pos_eval_sweep (N=3, M=2): table of sweep cases with a scoreboard
// of expected (vec, f) pairs, plus random masks and a mid-sweep reset.
module tb_pos_eval_sweep;

  logic       clk;
  logic       reset;
  logic       start;
  logic       hold;
  logic [5:0] lit_en;
  logic [5:0] lit_neg;
  logic       busy;
  logic       valid;
  logic [2:0] vec;
  logic       f;
  logic       done;
  logic [7:0] tt;
  logic [3:0] ones;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] v;
    logic       fv;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic [5:0] en;
    logic [5:0] neg;
    logic [7:0] ett;
    int         eones;
    int         hold_len;
    int         hold_vec;
    bit         restart;
    string      tag;
  } case_t;
  case_t cases[5];

  pos_eval_sweep #(.N(3), .M(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .hold   (hold),
    .lit_en (lit_en),
    .lit_neg(lit_neg),
    .busy   (busy),
    .valid  (valid),
    .vec    (vec),
    .f      (f),
    .done   (done),
    .tt     (tt),
    .ones   (ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: clause true if some enabled literal is true under v.
  function automatic logic model_f(input logic [5:0] en, input logic [5:0] neg, input logic [2:0] v);
    logic res;
    logic sat;
    res = 1'b1;
    for (int j = 0; j < 2; j++) begin
      sat = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (en[j*3+i]) begin
          if (neg[j*3+i] ? !v[i] : v[i]) sat = 1'b1;
        end
      end
      if (!sat) res = 1'b0;
    end
    return res;
  endfunction

  // One full sweep; c counts cycles after the accepting edge (c=1 is T+1).
  task automatic run_sweep(input logic [5:0] en, input logic [5:0] neg, input logic [7:0] ett,
                           input int eones, input int hold_len, input int hold_vec,
                           input bit restart, input string tag);
    int  exp_done;
    bit  seen;
    exp_t e;
    @(negedge clk);
    start   = 1'b1;
    lit_en  = en;
    lit_neg = neg;
    for (int k = 0; k < 8; k++) q.push_back('{v: 3'(k), fv: ett[k]});
    exp_done = 9 + hold_len;
    seen = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      start   = restart && (c == 3 || c == exp_done);
      hold    = (hold_len > 0) && (c >= hold_vec + 1) && (c < hold_vec + 1 + hold_len);
      lit_en  = 6'($urandom);
      lit_neg = 6'($urandom);
      #1;
      chk({tag, " busy"}, 32'(busy), 32'(c < exp_done));
      chk({tag, " done"}, 32'(done), 32'(c == exp_done));
      if (hold) begin
        chk({tag, " held valid"}, 32'(valid), 32'd0);
        chk({tag, " held vec"}, 32'(vec), 32'(hold_vec));
      end
      if (valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s extra valid: vec %0d with no expected entry", tag, vec);
        end else begin
          e = q.pop_front();
          chk({tag, " vec"}, 32'(vec), 32'(e.v));
          chk({tag, " f"}, 32'(f), 32'(e.fv));
        end
      end
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s done timeout: got no done, expected at T+%0d", tag, exp_done);
    end
    chk({tag, " tt"}, 32'(tt), 32'(ett));
    chk({tag, " ones"}, 32'(ones), 32'(eones));
    chk({tag, " queue empty"}, 32'(q.size()), 32'd0);
    q.delete();
    @(negedge clk);
    start = 1'b0;
    hold  = 1'b0;
    #1;
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
    chk({tag, " idle done"}, 32'(done), 32'd0);
    chk({tag, " idle valid"}, 32'(valid), 32'd0);
    chk({tag, " idle tt"}, 32'(tt), 32'(ett));
    chk({tag, " idle ones"}, 32'(ones), 32'(eones));
    chk({tag, " idle vec"}, 32'(vec), 32'd7);
  endtask

  initial begin
    logic [5:0] ren;
    logic [5:0] rneg;
    logic [7:0] rtt;
    int         rones;

    // x + y' and y' + z' : en = {011,110}, neg = {011,010}
    cases[0] = '{6'b011110, 6'b011010, 8'h73, 5, 0, 0, 1'b0, "pos_basic"};
    cases[1] = '{6'b000000, 6'b000000, 8'h00, 0, 0, 0, 1'b0, "empty"};
    cases[2] = '{6'b100100, 6'b000000, 8'hF0, 4, 0, 0, 1'b0, "x_only"};
    cases[3] = '{6'b011110, 6'b011010, 8'h73, 5, 3, 4, 1'b0, "hold"};
    cases[4] = '{6'b011110, 6'b011010, 8'h73, 5, 0, 0, 1'b1, "restart"};

    reset   = 1'b1;
    start   = 1'b0;
    hold    = 1'b0;
    lit_en  = '0;
    lit_neg = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst valid", 32'(valid), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst vec", 32'(vec), 32'd0);
    chk("rst f", 32'(f), 32'd0);
    chk("rst tt", 32'(tt), 32'd0);
    chk("rst ones", 32'(ones), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int n = 0; n < 5; n++) begin
      run_sweep(cases[n].en, cases[n].neg, cases[n].ett, cases[n].eones,
                cases[n].hold_len, cases[n].hold_vec, cases[n].restart, cases[n].tag);
    end

    // Random masks against the reference model.
    for (int r = 0; r < 4; r++) begin
      ren   = 6'($urandom);
      rneg  = 6'($urandom);
      rtt   = '0;
      rones = 0;
      for (int k = 0; k < 8; k++) begin
        rtt[k] = model_f(ren, rneg, 3'(k));
        if (rtt[k]) rones++;
      end
      run_sweep(ren, rneg, rtt, rones, 0, 0, 1'b0, "random");
    end

    // Reset during the sweep: reset sampled at the edge ending T+4.
    @(negedge clk);
    start   = 1'b1;
    lit_en  = 6'b011110;
    lit_neg = 6'b011010;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort valid", 32'(valid), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort vec", 32'(vec), 32'd0);
    chk("abort f", 32'(f), 32'd0);
    chk("abort tt", 32'(tt), 32'd0);
    chk("abort ones", 32'(ones), 32'd0);
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      chk("abort no done", 32'(done), 32'd0);
      chk("abort stays idle", 32'(busy), 32'd0);
    end
    run_sweep(6'b011110, 6'b011010, 8'h73, 5, 0, 0, 1'b0, "after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pos_eval_sweep.md
POS_EVAL_SWEEP -- requirements
Module: pos_eval_sweep

Interface
REQ-001 Parameter N, default 3, number of boolean input variables (1..8).
REQ-002 Parameter M, default 2, number of OR clauses in the product-of-sums expression (1..8).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
REQ-006 hold  input  1  pauses sweep advance while high.
REQ-007 lit_en  input  M*N  literal-present mask; bit j*N+i set means variable i appears in clause j.
REQ-008 lit_neg  input  M*N  literal-complement mask; bit j*N+i set means variable i appears complemented in clause j.
REQ-009 busy  output  1  high while in SWEEP.
REQ-010 valid  output  1  high when vec/f carry a fresh evaluation this cycle.
REQ-011 vec  output  N  current input combination; bit N-1 is the first variable (x), bit 0 the last.
REQ-012 f  output  1  expression value for vec.
REQ-013 done  output  1  one-cycle pulse at sweep completion.
REQ-014 tt  output  2^N  truth table; bit k holds f for vec = k.
REQ-015 ones  output  N+1  count of combinations with f = 1.

Function
REQ-016 States: IDLE, SWEEP, DONE; IDLE -> SWEEP on start; SWEEP -> DONE after vec = 2^N-1 is evaluated; DONE -> IDLE unconditionally after one cycle.
REQ-017 lit_en and lit_neg are latched on the start edge; later input changes do not affect the running sweep.
REQ-018 Clause j = OR over i of (lit_en[j*N+i] AND (vec[i] XOR lit_neg[j*N+i])); a clause with no enabled literal evaluates to 0.
REQ-019 f = AND of all M clauses, combinational from vec and the latched masks.
REQ-020 Start accepted in cycle T: tt and ones cleared, vec = 0, valid = 1 in cycle T+1.
REQ-021 Each non-held SWEEP cycle: valid = 1, tt[vec] <= f, ones <= ones + f, vec advances by 1 on the following edge.
REQ-022 hold = 1 in SWEEP: valid = 0, vec, tt and ones frozen; hold is ignored outside SWEEP.
REQ-023 With no hold, the last evaluation (vec = 2^N-1) occurs at T+2^N and done = 1 at T+2^N+1; each held cycle delays both by one.
REQ-024 vec does not wrap during a sweep; after the last evaluation it remains 2^N-1 until the next accepted start.
REQ-025 start while in SWEEP or DONE is ignored, with no queuing.
REQ-026 tt and ones hold their final values from done until the next accepted start.
REQ-027 ones width N+1 holds 2^N without overflow.

Reset
REQ-028 reset = 1 at a rising edge forces IDLE and sets busy = 0, valid = 0, done = 0, vec = 0, tt = 0, ones = 0 and latched masks = 0, with priority over start and hold.
REQ-029 Reset mid-sweep aborts the sweep with no done pulse; the next start after reset runs a full sweep from vec = 0.

Verification
REQ-030 N=3, M=2, clause0 = x + y' (lit_en bits 2,1; lit_neg bit 1), clause1 = y' + z' (lit_en bits 1,0; lit_neg bits 1,0), start at T -> valid T+1..T+8, f sequence for vec 0..7 = 1,1,0,0,1,1,1,0, tt = 8'h73, ones = 5, done at T+9 only.
REQ-031 All lit_en = 0, start -> every f = 0, tt = 8'h00, ones = 0, done at T+9.
REQ-032 Both clauses = x only (lit_en bit 2 per clause, lit_neg = 0), start -> tt = 8'hF0, ones = 4.
REQ-033 Default sweep with hold = 1 for 3 cycles while vec = 4 -> valid = 0 and vec = 4 in those cycles, done at T+12, tt = 8'h73.
REQ-034 start pulsed again at T+3 and in the DONE cycle -> both ignored: single done pulse, results unchanged, return to IDLE.
REQ-035 reset at T+4 mid-sweep -> next cycle shows IDLE, all outputs 0, no done pulse; a new start then reproduces tt = 8'h73, ones = 5.
